// File: rtl/radix8_pkg.sv
// Shared constants and state encoding for the radix-8 Booth recoder.
package radix8_pkg;

  localparam int unsigned NUM_DIGITS = 11;
  localparam int unsigned OP_W       = 32;
  localparam int unsigned A3_W       = 35;
  localparam int unsigned IDX_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRECOMP,
    ST_EMIT
  } state_e;

endpackage

// File: rtl/radix8_digit_enc.sv
// Radix-8 Booth digit encoder: 4-bit overlapping group -> magnitude (0..4) and sign.
module radix8_digit_enc (
  input  logic [3:0] grp_i,
  output logic [2:0] mag_o,
  output logic       neg_o
);

  logic [2:0] pos_sum;

  always_comb begin
    // 2*b2 + b1 + b0 is the non-negative part; b3 contributes -4.
    pos_sum = {1'b0, grp_i[2], 1'b0} + {2'b00, grp_i[1]} + {2'b00, grp_i[0]};
    mag_o   = pos_sum;
    neg_o   = 1'b0;
    if (grp_i[3]) begin
      mag_o = 3'd4 - pos_sum;
      neg_o = (pos_sum != 3'd4);
    end
  end

endmodule

// File: rtl/radix8_booth_recoder.sv
// Radix-8 Booth recoder: captures a/x, precomputes 3*a, streams 11 digits with valid/ready.
// Optional reconstruction checker enabled by RADIX8_RECODE_CHECK_EN.
module radix8_booth_recoder
  import radix8_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] x,
  input  logic        digit_ready,
  output logic        digit_valid,
  output logic [2:0]  digit_mag,
  output logic        digit_neg,
  output logic [3:0]  digit_idx,
  output logic        digit_last,
  output logic [31:0] a_reg,
  output logic [34:0] a3,
  output logic        busy,
  output logic        done,
  output logic        chk_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   a_q, x_q;
  logic [A3_W-1:0]   a3_q;
  logic [IDX_W-1:0]  idx_q;
  logic              done_q;

  logic              emit, xfer, xfer_last, accept;
  logic [OP_W+1:0]   x_ext;
  logic [5:0]        shamt;
  logic [3:0]        grp;
  logic [2:0]        enc_mag;
  logic              enc_neg;

  assign emit      = (state_q == ST_EMIT);
  assign xfer      = emit && digit_ready;
  assign xfer_last = xfer && (idx_q == LAST_IDX);
  assign accept    = (state_q == ST_IDLE) && start;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start) state_d = ST_PRECOMP;
      ST_PRECOMP: state_d = ST_EMIT;
      ST_EMIT:    if (xfer_last) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      x_q    <= '0;
      a3_q   <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= xfer_last;
      if (accept) begin
        a_q   <= a;
        x_q   <= x;
        idx_q <= '0;
      end
      if (state_q == ST_PRECOMP)
        a3_q <= {{3{a_q[31]}}, a_q} + {{2{a_q[31]}}, a_q, 1'b0};
      if (xfer && !xfer_last)
        idx_q <= idx_q + 1'b1;
    end
  end

  // x_ext[0] is the implicit x[-1]=0 and x_ext[33] repeats the sign, so group i is x_ext[3i+3:3i].
  assign x_ext = {x_q[31], x_q, 1'b0};
  assign shamt = 6'(idx_q) * 6'd3;
  assign grp   = 4'(x_ext >> shamt);

  radix8_digit_enc u_enc (
    .grp_i (grp),
    .mag_o (enc_mag),
    .neg_o (enc_neg)
  );

  assign digit_valid = emit;
  assign digit_mag   = emit ? enc_mag : '0;
  assign digit_neg   = emit ? enc_neg : 1'b0;
  assign digit_idx   = emit ? idx_q : '0;
  assign digit_last  = emit && (idx_q == LAST_IDX);
  assign a_reg       = a_q;
  assign a3          = a3_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;

`ifdef RADIX8_RECODE_CHECK_EN
  logic signed [3:0]  chk_digit;
  logic signed [35:0] acc_q, acc_d;
  logic               chk_q;

  assign chk_digit = enc_neg ? -$signed({1'b0, enc_mag}) : $signed({1'b0, enc_mag});
  assign acc_d     = acc_q + (36'(chk_digit) <<< shamt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      chk_q <= 1'b0;
    end else if (accept) begin
      acc_q <= '0;
      chk_q <= 1'b0;
    end else if (xfer) begin
      acc_q <= acc_d;
      if (xfer_last)
        chk_q <= (acc_d != $signed({{4{x_q[31]}}, x_q}));
    end
  end

  assign chk_err = chk_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_radix8_booth_recoder.sv
// Directed self-checking bench for radix8_booth_recoder.
module tb_radix8_booth_recoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, x;
  logic        digit_ready;
  logic        digit_valid;
  logic [2:0]  digit_mag;
  logic        digit_neg;
  logic [3:0]  digit_idx;
  logic        digit_last;
  logic [31:0] a_reg;
  logic [34:0] a3;
  logic        busy, done, chk_err;

  int n_checks = 0;
  int n_err    = 0;

  radix8_booth_recoder dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .x           (x),
    .digit_ready (digit_ready),
    .digit_valid (digit_valid),
    .digit_mag   (digit_mag),
    .digit_neg   (digit_neg),
    .digit_idx   (digit_idx),
    .digit_last  (digit_last),
    .a_reg       (a_reg),
    .a3          (a3),
    .busy        (busy),
    .done        (done),
    .chk_err     (chk_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {48'h0, digit_valid, digit_mag, digit_neg, digit_idx, digit_last,
            a_reg, a3, busy, done, chk_err};
  endfunction

  // mode 0: ready held high; mode 1: ready pattern 1,0,0 with start/a/x disturbed during EMIT.
  // expd holds {neg,mag} per digit, nibble i = digit i.
  task automatic run_op(input logic [31:0] av, input logic [31:0] xv, input int mode,
                        input logic [43:0] expd, input int exp_edges);
    int n, cnt;
    logic held;
    logic [8:0] prev;
    start = 1'b1; a = av; x = xv; digit_ready = (mode == 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("accept_busy", busy, 1'b1);
    check("precomp_valid", digit_valid, 1'b0);
    @(posedge clk); #1;
    n = 0; cnt = 0; held = 1'b0; prev = '0;
    while (n < 11 && cnt < 100) begin
      if (mode == 1) begin
        digit_ready = (cnt % 3 == 0);
        start = 1'b1; a = 32'hFFFF_FFFF; x = 32'h5555_5555;
      end
      check("valid", digit_valid, 1'b1);
      check("idx", digit_idx, n);
      check("digit", {digit_neg, digit_mag}, expd[4*n +: 4]);
      check("last", digit_last, (n == 10));
      if (held) check("hold", {digit_idx, digit_neg, digit_mag, digit_last}, prev);
      held = !digit_ready;
      prev = {digit_idx, digit_neg, digit_mag, digit_last};
      if (digit_ready) n++;
      @(posedge clk); #1;
      cnt++;
    end
    start = 1'b0;
    check("transfers", n, 11);
    check("done_pulse", done, 1'b1);
    check("done_busy", busy, 1'b0);
    check("done_valid", digit_valid, 1'b0);
    if (exp_edges > 0) check("latency", cnt + 1, exp_edges);
  endtask

  initial begin
    int w;
    logic saw;
    rst = 1'b1; start = 1'b0; digit_ready = 1'b0; a = '0; x = '0;
    #12;
    check("reset_outs", all_outs(), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("idle_outs", all_outs(), '0);

    run_op(32'd5, 32'hFFFF_FFFF, 0, 44'h00000000009, 12);
    check("a3_x_m1", a3, 35'hF);
    check("areg_x_m1", a_reg, 32'd5);
    check("chk_x_m1", chk_err, 1'b0);

    run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 44'h20000000009, 12);
    check("a3_max", a3, 35'h17FFFFFFD);
    @(posedge clk); #1;
    check("done_one_cycle", done, 1'b0);

    run_op(32'hFFFF_FFFD, 32'd34, 0, 44'h000000001C2, 12);
    check("a3_m3", a3, 35'h7FFFFFFF7);
    check("chk_34", chk_err, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    run_op(32'h8000_0000, 32'hFFFF_FFF9, 1, 44'h00000000091, -1);
    check("a3_min", a3, 35'h680000000);
    check("areg_held", a_reg, 32'h8000_0000);
    @(posedge clk); #1;
    check("start_in_emit_ignored", busy, 1'b0);

    start = 1'b1; a = 32'd9; x = 32'hDEAD_BEEF; digit_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (digit_idx != 4'd5 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("reach_digit5", digit_idx, 4'd5);
    #2 rst = 1'b1;
    #1 check("async_reset_outs", all_outs(), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    saw = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) saw = 1'b1;
    end
    check("no_done_after_abort", saw, 1'b0);
    check("idle_after_abort", busy, 1'b0);
    run_op(32'd1, 32'd12, 0, 44'h0000000002C, 12);
    check("a3_after_abort", a3, 35'h3);

`ifdef RADIX8_RECODE_CHECK_EN
    start = 1'b1; a = 32'd2; x = 32'hFFFF_FFFF; digit_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (digit_idx != 4'd3 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("reach_digit3", digit_idx, 4'd3);
    force dut.chk_digit = 4'sd1;
    @(posedge clk); #1;
    release dut.chk_digit;
    w = 0;
    while (!done && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("corrupt_done", done, 1'b1);
    check("corrupt_chk_err", chk_err, 1'b1);
    run_op(32'd2, 32'd34, 0, 44'h000000001C2, 12);
    check("chk_cleared", chk_err, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/radix8_booth_recoder.md
RADIX8_BOOTH_RECODER -- requirements
Module: radix8_booth_recoder

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous reset, active-high.
REQ-003 start  input  1  request to recode a new operand pair; sampled only in IDLE.
REQ-004 a  input  32  signed multiplicand; captured on accepted start.
REQ-005 x  input  32  signed multiplier; captured on accepted start.
REQ-006 digit_ready  input  1  downstream multiplier accepts the current digit.
REQ-007 digit_valid  output  1  digit_mag, digit_neg, digit_idx and digit_last are valid.
REQ-008 digit_mag  output  3  Booth digit magnitude, 0..4.
REQ-009 digit_neg  output  1  Booth digit sign; 1 means negative, and it is 0 whenever digit_mag is 0.
REQ-010 digit_idx  output  4  digit index, 0..10, LSB group first.
REQ-011 digit_last  output  1  current digit is index 10.
REQ-012 a_reg  output  32  captured multiplicand, held until the next accepted start.
REQ-013 a3  output  35  registered hard multiple 3*a, signed.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse after the last digit transfers.
REQ-016 chk_err  output  1  reconstruction mismatch flag (see Configuration).

Function
REQ-017 States SHALL be IDLE, PRECOMP and EMIT.
- IDLE->PRECOMP on start.
- PRECOMP->EMIT unconditionally after one cycle.
- EMIT->IDLE on transfer of digit 10.
REQ-018 In IDLE, start=1 SHALL capture a and x, and clear the digit index to 0.
- start in PRECOMP or EMIT is ignored.
REQ-019 In PRECOMP, a3 SHALL be registered as sign-extended a + (a<<1), 35 bits, with no overflow.
REQ-020 The multiplier SHALL be extended to x[33:32]=x[31] and x[-1]=0.
- Digit i uses bits (x[3i+2], x[3i+1], x[3i], x[3i-1]).
- Digit value = -4*x[3i+2] + 2*x[3i+1] + x[3i] + x[3i-1].
- Range -4..+4.
REQ-021 digit_valid SHALL be 1 throughout EMIT and 0 otherwise.
- First valid digit appears one cycle after PRECOMP, i.e. two cycles after start is sampled.
REQ-022 A transfer SHALL occur on a rising edge with digit_valid && digit_ready; digit_idx then increments.
REQ-023 While digit_valid && !digit_ready, all digit outputs SHALL hold stable.
REQ-024 With digit_ready held high, 11 digits SHALL transfer on 11 consecutive edges.
- start-to-done = 13 cycles.
REQ-025 done SHALL pulse high for exactly the one cycle after the digit-10 transfer; busy is 0 in that cycle.
- A start in that cycle is accepted.
REQ-026 Back-pressure of any length SHALL NOT lose or duplicate a digit.

Reset
REQ-027 When rst is asserted, all outputs SHALL be 0 and the state SHALL be IDLE, immediately and asynchronously.
REQ-028 Reset asserted mid-operation SHALL abandon the operand with no done pulse.
- After reset releases, the next start begins fresh from digit 0.

Configuration
REQ-029 Macro RADIX8_RECODE_CHECK_EN.
- When defined: a 36-bit signed accumulator sums digit*8^i on each transfer.
- After the digit-10 transfer, chk_err is set if sum != sign-extended x, and held until the next accepted start or reset.
REQ-030 When RADIX8_RECODE_CHECK_EN is undefined, chk_err SHALL be tied to 0 and no accumulator is built.

Structure
REQ-031 Shared package radix8_pkg SHALL hold:
- NUM_DIGITS=11
- operand width 32, a3 width 35
- the state enum
REQ-032 Sub-module radix8_digit_enc SHALL be used: combinational 4-bit group -> {digit_mag, digit_neg}.
- It is instantiated once and indexed by the digit counter.

Verification
REQ-033 x=32'hFFFFFFFF, ready=1 -> digits (mag,neg) = (1,1), then ten (0,0); done 13 cycles after start.
REQ-034 x=32'h7FFFFFFF, a=32'h7FFFFFFF -> digit0=(1,1), digits 1..9=(0,0), digit10=(2,0); a3=35'h17FFFFFFD.
REQ-035 x=34, a=-3 -> digits 0..2 = (2,0), (4,1), (1,0), rest (0,0); a3=-9.
REQ-036 x=-7 with ready toggling 1,0,0,1,... -> digits (1,0), (1,1), then zeros.
- Each digit held unchanged while ready=0.
- Exactly 11 transfers.
REQ-037 Assert rst during digit 5 of any operand -> all outputs 0 at once; no done pulse.
- A new start with x=12 then yields (4,1), (2,0), then zeros.
REQ-038 With RADIX8_RECODE_CHECK_EN defined: checker forced to corrupt digit 3 -> chk_err=1 after the last digit; normal runs -> chk_err=0.
